// File: rtl/mem_ctrl_if.sv
// Single-outstanding req/ack data bus between the MEM-stage load/store
// sequencer (master) and the data memory (slave).
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [3:0]        bus_be_o;
  logic [31:0]       bus_wdata_o;
  logic [31:0]       bus_rdata_i;
  logic              bus_ack_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/mem_ctrl.sv
// MEM-stage load/store sequencer: IDLE -> REQ -> DONE over a req/ack bus.
// Optional bus timeout abort is built only when MEM_TIMEOUT_EN is defined.
module mem_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       w_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  mem_ctrl_if.master        bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       mem_data_q, mem_data_d;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
  logic              bus_err_c;
`endif

  logic        acc, aligned, type_ok, legal;
  logic        stall_c, misalign_c;
  logic [3:0]  be_st;
  logic [31:0] wdata_st;

  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'd0, b};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Decode of the access presented by EX/MEM; a simultaneous read and write is a write.
  always_comb begin
    acc = MemRead_i | MemWrite_i;
    case (funct3_i[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_i[0];
      2'b10:   aligned = (addr_i[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    if (MemWrite_i) type_ok = ~funct3_i[2] && (funct3_i[1:0] != 2'b11);
    else            type_ok = (funct3_i[1:0] != 2'b11) && (funct3_i != 3'b110);
    legal = aligned & type_ok;

    case (funct3_i[1:0])
      2'b00: begin
        be_st    = 4'b0001 << addr_i[1:0];
        wdata_st = {4{w_data_i[7:0]}};
      end
      2'b01: begin
        be_st    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_st = {2{w_data_i[15:0]}};
      end
      default: begin
        be_st    = 4'b1111;
        wdata_st = w_data_i;
      end
    endcase
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    mem_data_d = mem_data_q;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    bus_err_c  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (acc && legal) begin
          stall_c  = 1'b1;
          req_d    = 1'b1;
          we_d     = MemWrite_i;
          addr_d   = {addr_i[ADDR_W-1:2], 2'b00};
          be_d     = MemWrite_i ? be_st : 4'b1111;
          wdata_d  = MemWrite_i ? wdata_st : 32'd0;
          funct3_d = funct3_i;
          off_d    = addr_i[1:0];
          state_d  = REQ;
`ifdef MEM_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end else if (acc) begin
          misalign_c = 1'b1;
        end
      end

      REQ: begin
        stall_c = 1'b1;
        if (bus.bus_ack_i) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) mem_data_d = fmt_load(funct3_q, off_q, bus.bus_rdata_i);
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          req_d     = 1'b0;
          bus_err_c = 1'b1;
          state_d   = DONE;
          if (!we_q) mem_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end

      // Same instruction is still presented here; it advances on this edge.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      mem_data_q <= 32'd0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      mem_data_q <= mem_data_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Combinational outputs are gated so reset forces every output low immediately.
  assign stall_o         = stall_c & ~rst_i;
  assign misalign_o      = misalign_c & ~rst_i;
  assign mem_data_o      = mem_data_q;
  assign bus.bus_req_o   = req_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_be_o    = be_q;
  assign bus.bus_wdata_o = wdata_q;

`ifdef MEM_TIMEOUT_EN
  assign bus_err_o = bus_err_c & ~rst_i;
`else
  assign bus_err_o = 1'b0 && (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table plus reset/timeout sequences.
module tb_mem_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, w_data;
  logic [31:0] mem_data;
  logic        stall, misalign, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_ctrl_if #(.ADDR_W(32)) bus_if ();

  mem_ctrl #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (mem_read),
    .MemWrite_i (mem_write),
    .funct3_i   (funct3),
    .addr_i     (addr),
    .w_data_i   (w_data),
    .mem_data_o (mem_data),
    .stall_o    (stall),
    .misalign_o (misalign),
    .bus_err_o  (bus_err),
    .bus        (bus_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_mem;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mem;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'd0;
    addr      = 32'd0;
    w_data    = 32'd0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    w_data    = wd;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   stall_cycles;
    @(negedge clk_i);
    drive(v.rd, v.wr, v.f3, v.addr, v.wdata);
    #1;
    if (v.exp_mis) begin
      check({tag, " misalign"}, misalign, 1);
      check({tag, " mis_stall"}, stall, 0);
      @(negedge clk_i);
      idle_inputs();
      #1;
      check({tag, " mis_req"}, bus_if.bus_req_o, 0);
      check({tag, " mis_pulse_end"}, misalign, 0);
      check({tag, " mis_mem"}, mem_data, v.exp_mem);
      return;
    end
    check({tag, " idle_stall"}, stall, 1);
    check({tag, " no_misalign"}, misalign, 0);
    sb_q.push_back('{we: v.wr, addr: v.exp_addr, be: v.exp_be,
                     wdata: v.exp_wdata, mem: v.exp_mem});
    stall_cycles = 1;
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge clk_i);
      #1;
      if (stall) stall_cycles++;
      if (bus_if.bus_req_o !== 1'b1) begin
        check({tag, " req_held"}, bus_if.bus_req_o, 1);
        break;
      end
      if (k == 0) begin
        if (sb_q.size() == 0) begin
          check({tag, " scoreboard_empty"}, 1, 0);
          e = '{we: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0, mem: 32'd0};
        end else begin
          e = sb_q.pop_front();
        end
        check({tag, " we"}, bus_if.bus_we_o, e.we);
        check({tag, " addr"}, bus_if.bus_addr_o, e.addr);
        check({tag, " be"}, bus_if.bus_be_o, e.be);
        if (e.we) check({tag, " wdata"}, bus_if.bus_wdata_o, e.wdata);
      end
      if (k == v.waits) begin
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = v.rdata;
      end
    end
    @(negedge clk_i);
    bus_if.bus_ack_i = 1'b0;
    #1;
    check({tag, " done_stall"}, stall, 0);
    check({tag, " done_req"}, bus_if.bus_req_o, 0);
    check({tag, " mem_data"}, mem_data, e.mem);
    check({tag, " stall_cycles"}, stall_cycles, v.waits + 2);
    @(negedge clk_i);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   err_cycle;

    //          rd    wr    f3      addr      wdata          rdata          w  mis   eaddr     ebe      ewdata         emem
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 1'b0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0, 1'b0, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0, 1'b0, 32'h100, 4'b1111, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80112233, 0, 1'b0, 32'h100, 4'b1111, 32'h0,        32'h00008011};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80112233, 0, 1'b0, 32'h100, 4'b1111, 32'h0,        32'hFFFF8011};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h80112233, 2, 1'b0, 32'h100, 4'b1111, 32'h0,        32'h00002233};
    vecs[6]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h80112233, 3, 1'b0, 32'h100, 4'b1111, 32'h0,        32'h00000022};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'hDEADBEEF, 0, 1'b0, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h00000022};
    vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'hDEADBEEF, 1, 1'b0, 32'h200, 4'b1100, 32'h12341234, 32'h00000022};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'hDEADBEEF, 0, 1'b0, 32'h204, 4'b1111, 32'hCAFEF00D, 32'h00000022};
    vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h200, 32'hABCD5678, 32'hDEADBEEF, 0, 1'b0, 32'h200, 4'b0011, 32'h56785678, 32'h00000022};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 32'h203, 32'h00000011, 32'hDEADBEEF, 0, 1'b0, 32'h200, 4'b1000, 32'h11111111, 32'h00000022};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h300, 32'h00000055, 32'hDEADBEEF, 0, 1'b0, 32'h300, 4'b1111, 32'h00000055, 32'h00000022};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h00000022};
    vecs[14] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h00000022};
    vecs[15] = '{1'b1, 1'b0, 3'b110, 32'h000, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h00000022};
    vecs[16] = '{1'b0, 1'b1, 3'b100, 32'h000, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h00000022};
    vecs[17] = '{1'b0, 1'b1, 3'b001, 32'h201, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h00000022};
    vecs[18] = '{1'b1, 1'b0, 3'b010, 32'h108, 32'h0,        32'h12345678, 0, 1'b0, 32'h108, 4'b1111, 32'h0,        32'h12345678};
    vecs[19] = '{1'b1, 1'b0, 3'b101, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h12345678};

    // Reset with a legal load presented: every output must stay low.
    rst_i              = 1'b1;
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = 32'd0;
    drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    repeat (2) @(negedge clk_i);
    #1;
    check("rst stall", stall, 0);
    check("rst req", bus_if.bus_req_o, 0);
    check("rst mem_data", mem_data, 0);
    check("rst misalign", misalign, 0);
    check("rst bus_err", bus_err, 0);
    check("rst be", bus_if.bus_be_o, 0);
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b0;

    for (int i = 0; i < 20; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Ack while idle must be ignored.
    @(negedge clk_i);
    bus_if.bus_ack_i   = 1'b1;
    bus_if.bus_rdata_i = 32'hFFFFFFFF;
    @(negedge clk_i);
    bus_if.bus_ack_i = 1'b0;
    #1;
    check("idle_ack mem_data", mem_data, 32'h12345678);
    check("idle_ack stall", stall, 0);
    check("idle_ack req", bus_if.bus_req_o, 0);

`ifdef MEM_TIMEOUT_EN
    // No ack: error pulse in the 16th REQ cycle, then DONE.
    @(negedge clk_i);
    drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    err_cycle = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      #1;
      if (bus_err) begin
        err_cycle = k;
        break;
      end
    end
    check("tmo err_cycle", err_cycle, 16);
    check("tmo req_in_err_cycle", bus_if.bus_req_o, 1);
    @(negedge clk_i);
    #1;
    check("tmo done_stall", stall, 0);
    check("tmo done_req", bus_if.bus_req_o, 0);
    check("tmo err_pulse_end", bus_err, 0);
    check("tmo mem_data", mem_data, 0);
    @(negedge clk_i);
    idle_inputs();

    // Ack in the timeout cycle wins.
    @(negedge clk_i);
    drive(1'b1, 1'b0, 3'b010, 32'h504, 32'h0);
    for (int k = 1; k <= 16; k++) @(negedge clk_i);
    bus_if.bus_ack_i   = 1'b1;
    bus_if.bus_rdata_i = 32'h0BADF00D;
    #1;
    check("tmo_ack no_err", bus_err, 0);
    @(negedge clk_i);
    bus_if.bus_ack_i = 1'b0;
    #1;
    check("tmo_ack mem_data", mem_data, 32'h0BADF00D);
    check("tmo_ack stall", stall, 0);
    @(negedge clk_i);
    idle_inputs();
`else
    // Without the timeout the request waits indefinitely.
    @(negedge clk_i);
    drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    err_cycle = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      #1;
      if (bus_err || !bus_if.bus_req_o) err_cycle = k;
    end
    check("wait no_err_no_drop", err_cycle, 0);
    check("wait stall", stall, 1);
    bus_if.bus_ack_i   = 1'b1;
    bus_if.bus_rdata_i = 32'h00007777;
    @(negedge clk_i);
    bus_if.bus_ack_i = 1'b0;
    #1;
    check("wait mem_data", mem_data, 32'h00007777);
    check("wait stall_done", stall, 0);
    @(negedge clk_i);
    idle_inputs();
`endif

    // Asynchronous reset in the middle of REQ, then a stray ack.
    @(negedge clk_i);
    drive(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    @(negedge clk_i);
    #1;
    check("arst pre_req", bus_if.bus_req_o, 1);
    #1;
    rst_i = 1'b1;
    #1;
    check("arst req", bus_if.bus_req_o, 0);
    check("arst stall", stall, 0);
    check("arst mem_data", mem_data, 0);
    idle_inputs();
    @(negedge clk_i);
    rst_i              = 1'b0;
    bus_if.bus_ack_i   = 1'b1;
    bus_if.bus_rdata_i = 32'hFFFFFFFF;
    #1;
    check("arst late_ack stall", stall, 0);
    @(negedge clk_i);
    bus_if.bus_ack_i = 1'b0;
    #1;
    check("arst late_ack mem_data", mem_data, 0);
    check("arst late_ack req", bus_if.bus_req_o, 0);

    v = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 0, 1'b0,
          32'h104, 4'b1111, 32'h0, 32'h13579BDF};
    run_vec(v, "post_rst");

    check("scoreboard drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
